// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: instruction layout, fetch state
// encoding and the default reset program counter.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned PC_W       = 16;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned IMMSRC_MSB = 7;
  localparam int unsigned IMMSRC_LSB = 0;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  // REQ: a memory read is outstanding. HOLD: an instruction waits for decode.
  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetchState_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register.
//   i_clk      clock, rising edge
//   i_rstn     synchronous active-low reset, loads RESET_PC
//   i_load     load i_loadAddr (wins over i_inc)
//   i_loadAddr redirect target
//   i_inc      advance by PC_STEP (16-bit modulo)
//   o_pc       current program counter
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = 16'd2
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_loadAddr,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] pcQ;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pcQ <= RESET_PC;
    end else if (i_load) begin
      pcQ <= i_loadAddr;
    end else if (i_inc) begin
      pcQ <= pcQ + PC_STEP;
    end
  end

  assign o_pc = pcQ;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC, issues one outstanding memory read at
// a time, latches the returned word and hands it to decode over valid/ready.
//   i_clk, i_rstn        clock / synchronous active-low reset
//   o_memReq, o_memAddr  read request and address (address = PC)
//   i_memAck, i_memData  one-cycle acknowledge with returned instruction
//   o_valid, i_ready     handshake towards decode
//   o_instr, o_pc        instruction register and its address
//   o_opcode, o_immSrc   pre-split fields of o_instr
//   i_redirValid/Addr    branch/jump redirect (target bit 0 forced to 0)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = 16'd2
) (
  input  logic                             i_clk,
  input  logic                             i_rstn,
  output logic                             o_memReq,
  output logic [PC_W-1:0]                  o_memAddr,
  input  logic                             i_memAck,
  input  logic [INSTR_W-1:0]               i_memData,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [INSTR_W-1:0]               o_instr,
  output logic [PC_W-1:0]                  o_pc,
  output logic [OPCODE_MSB-OPCODE_LSB:0]   o_opcode,
  output logic [IMMSRC_MSB-IMMSRC_LSB:0]   o_immSrc,
  input  logic                             i_redirValid,
  input  logic [PC_W-1:0]                  i_redirAddr
);

  fetchState_t        state, stateNext;
  logic               dropFlag, dropNext;
  logic [INSTR_W-1:0] instrReg;
  logic [PC_W-1:0]    pcOut;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    redirTarget;
  logic               pcLoad, pcInc, captureInstr;

  assign redirTarget = i_redirAddr & ~16'h0001;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) uPcReg (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (pcLoad),
    .i_loadAddr (redirTarget),
    .i_inc      (pcInc),
    .o_pc       (pc)
  );

  // State register, drop flag and instruction/pc capture.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= REQ;
      dropFlag <= 1'b0;
      instrReg <= '0;
      pcOut    <= '0;
    end else begin
      state    <= stateNext;
      dropFlag <= dropNext;
      if (captureInstr) begin
        instrReg <= i_memData;
        pcOut    <= pc;
      end
    end
  end

  // Next-state logic. A redirect overrides everything else.
  always_comb begin
    stateNext    = state;
    dropNext     = dropFlag;
    pcLoad       = 1'b0;
    pcInc        = 1'b0;
    captureInstr = 1'b0;
    if (i_redirValid) begin
      pcLoad = 1'b1;
      unique case (state)
        HOLD: stateNext = REQ;
        // The in-flight read cannot be cancelled: if it has not returned
        // yet its data must be discarded later. A read that returns in the
        // redirect cycle (stale or not) is discarded right here, so the
        // flag ends up clear in that case.
        REQ:  dropNext = !i_memAck;
        default: stateNext = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (i_memAck) begin
            if (dropFlag) begin
              dropNext = 1'b0;
            end else begin
              captureInstr = 1'b1;
              pcInc        = 1'b1;
              stateNext    = HOLD;
            end
          end
        end
        HOLD: begin
          if (i_ready) stateNext = REQ;
        end
        default: stateNext = REQ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    o_memReq = (state == REQ) && i_rstn;
    o_valid  = (state == HOLD);
  end

  assign o_memAddr = pc;
  assign o_instr   = instrReg;
  assign o_pc      = pcOut;
  assign o_opcode  = instrReg[OPCODE_MSB:OPCODE_LSB];
  assign o_immSrc  = instrReg[IMMSRC_MSB:IMMSRC_LSB];

endmodule
